shift_alu_ctrl: RTL and testbench

SHIFT_ALU_CTRL -- requirements
Module: shift_alu_ctrl

---
 rtl/shift_alu_ctrl_pkg.sv | 23 ++
 rtl/ctrl_regfile.sv | 32 +++
 rtl/shift_alu_ctrl.sv | 142 ++++++++++++++
 tb/tb_shift_alu_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_alu_ctrl_pkg.sv
// Shared types and constants for the shift/ALU command controller:
// FSM state encoding, command kinds and datapath operation codes.
package shift_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic CMD_LOADI = 1'b0;
  localparam logic CMD_EXEC  = 1'b1;

  // Each code selects one ALU op and one shifter op; sel_out picks which result counts
  localparam logic [2:0] OP_PASS    = 3'd0;
  localparam logic [2:0] OP_ADD_ASR = 3'd1;
  localparam logic [2:0] OP_SUB_LSR = 3'd2;
  localparam logic [2:0] OP_AND_ROR = 3'd3;
  localparam logic [2:0] OP_OR_LSL  = 3'd4;
  localparam logic [2:0] OP_NOT_ROL = 3'd5;

endpackage

// File: rtl/ctrl_regfile.sv
// NREG x 8 operand register file: two asynchronous read ports,
// one synchronous write port, asynchronous clear.
module ctrl_regfile #(
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [7:0]    rdata1_o,
  input  logic [AW-1:0] raddr2_i,
  output logic [7:0]    rdata2_o
);

  logic [7:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= 8'd0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-write contents during the write cycle
  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/shift_alu_ctrl.sv
// Command controller that sequences an external shifter/ALU datapath:
// latches a command, presents operands, captures the result and responds.
module shift_alu_ctrl
  import shift_alu_ctrl_pkg::*;
#(
  parameter int NREG = 4,
  localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_kind,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [7:0]    cmd_imm,
  input  logic [2:0]    cmd_oper,
  input  logic          cmd_sel_out,
  input  logic          cmd_sel_shamt,
  input  logic [2:0]    cmd_shimm,
  output logic [7:0]    dp_inp1,
  output logic [7:0]    dp_inp2,
  output logic [2:0]    dp_shimm,
  output logic          dp_sel_shamt,
  output logic          dp_sel_out,
  output logic [2:0]    dp_oper,
  input  logic [7:0]    dp_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic [AW-1:0] rsp_rd,
  output logic          busy
);

  typedef struct packed {
    logic          kind;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [7:0]    imm;
    logic [2:0]    oper;
    logic          sel_out;
    logic          sel_shamt;
    logic [2:0]    shimm;
  } cmd_t;

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [7:0] res_q, res_d;

  logic       rf_we;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata1;
  logic [7:0] rf_rdata2;

  ctrl_regfile #(
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (rf_we),
    .waddr_i  (cmd_q.rd),
    .wdata_i  (rf_wdata),
    .raddr1_i (cmd_q.rs1),
    .rdata1_o (rf_rdata1),
    .raddr2_i (cmd_q.rs2),
    .rdata2_o (rf_rdata2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      res_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    res_d        = res_q;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    rsp_valid    = 1'b0;
    rsp_data     = 8'd0;
    rsp_rd       = '0;
    rf_we        = 1'b0;
    rf_wdata     = 8'd0;
    dp_inp1      = 8'd0;
    dp_inp2      = 8'd0;
    dp_oper      = 3'd0;
    dp_sel_out   = 1'b0;
    dp_sel_shamt = 1'b0;
    dp_shimm     = 3'd0;

    // Operands are presented in ISSUE and held unchanged through the capture cycle
    if (state_q == ST_ISSUE || (state_q == ST_CAPTURE && cmd_q.kind == CMD_EXEC)) begin
      dp_inp1      = rf_rdata1;
      dp_inp2      = rf_rdata2;
      dp_oper      = cmd_q.oper;
      dp_sel_out   = cmd_q.sel_out;
      dp_sel_shamt = cmd_q.sel_shamt;
      dp_shimm     = cmd_q.shimm;
    end

    unique case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_d = '{kind: cmd_kind, rd: cmd_rd, rs1: cmd_rs1, rs2: cmd_rs2,
                    imm: cmd_imm, oper: cmd_oper, sel_out: cmd_sel_out,
                    sel_shamt: cmd_sel_shamt, shimm: cmd_shimm};
          state_d = (cmd_kind == CMD_EXEC) ? ST_ISSUE : ST_CAPTURE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rf_we    = 1'b1;
        rf_wdata = (cmd_q.kind == CMD_EXEC) ? dp_out : cmd_q.imm;
        res_d    = rf_wdata;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = res_q;
        rsp_rd    = cmd_q.rd;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_alu_ctrl.sv
// Self-checking bench: an external behavioural shifter/ALU drives dp_out, and an
// architectural register model predicts every response for directed and random commands.
module tb_shift_alu_ctrl;
  import shift_alu_ctrl_pkg::*;

  localparam int NREG = 4;
  localparam int AW   = $clog2(NREG);

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_kind;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [7:0]    cmd_imm;
  logic [2:0]    cmd_oper;
  logic          cmd_sel_out;
  logic          cmd_sel_shamt;
  logic [2:0]    cmd_shimm;
  logic [7:0]    dp_inp1;
  logic [7:0]    dp_inp2;
  logic [2:0]    dp_shimm;
  logic          dp_sel_shamt;
  logic          dp_sel_out;
  logic [2:0]    dp_oper;
  logic [7:0]    dp_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_data;
  logic [AW-1:0] rsp_rd;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [NREG];
  logic [7:0] data;

  shift_alu_ctrl #(.NREG(NREG)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_kind      (cmd_kind),
    .cmd_rd        (cmd_rd),
    .cmd_rs1       (cmd_rs1),
    .cmd_rs2       (cmd_rs2),
    .cmd_imm       (cmd_imm),
    .cmd_oper      (cmd_oper),
    .cmd_sel_out   (cmd_sel_out),
    .cmd_sel_shamt (cmd_sel_shamt),
    .cmd_shimm     (cmd_shimm),
    .dp_inp1       (dp_inp1),
    .dp_inp2       (dp_inp2),
    .dp_shimm      (dp_shimm),
    .dp_sel_shamt  (dp_sel_shamt),
    .dp_sel_out    (dp_sel_out),
    .dp_oper       (dp_oper),
    .dp_out        (dp_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_rd        (rsp_rd),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shifter/ALU: codes 6 and 7 return a ^ b so pass-through is observable
  function automatic logic [7:0] refResult(input logic [2:0] oper, input logic selOut,
                                           input logic [7:0] a, input logic [7:0] b,
                                           input logic selSh, input logic [2:0] shimm);
    int amt;
    int wide;
    logic [7:0] r;
    amt = selSh ? int'(shimm) : int'(b % 8);
    if (!selOut) begin
      case (oper)
        OP_PASS:    r = a;
        OP_ADD_ASR: r = 8'((int'(a) + int'(b)) % 256);
        OP_SUB_LSR: r = 8'((int'(a) - int'(b) + 256) % 256);
        OP_AND_ROR: r = a & b;
        OP_OR_LSL:  r = a | b;
        OP_NOT_ROL: r = 8'(255 - int'(a));
        default:    r = a ^ b;
      endcase
    end else begin
      case (oper)
        OP_PASS:    r = a;
        OP_ADD_ASR: begin
          wide = (a >= 128) ? int'(a) - 256 : int'(a);
          r = 8'(((wide >>> amt) + 256) % 256);
        end
        OP_SUB_LSR: r = 8'(int'(a) / (1 << amt));
        OP_AND_ROR: r = 8'((int'(a) / (1 << amt)) + ((int'(a) * (1 << (8 - amt))) % 256));
        OP_OR_LSL:  r = 8'((int'(a) * (1 << amt)) % 256);
        OP_NOT_ROL: r = 8'(((int'(a) * (1 << amt)) % 256) + (int'(a) / (1 << (8 - amt))));
        default:    r = a ^ b;
      endcase
    end
    return r;
  endfunction

  always_comb dp_out = refResult(dp_oper, dp_sel_out, dp_inp1, dp_inp2, dp_sel_shamt, dp_shimm);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dpBundle();
    return 32'({dp_inp1, dp_inp2, dp_oper, dp_sel_out, dp_sel_shamt, dp_shimm});
  endfunction

  // Offers one command, follows it to the RESP state and checks it against the model
  task automatic applyStimulus(input logic kind, input int rd, input int rs1, input int rs2,
                               input logic [7:0] imm, input logic [2:0] oper,
                               input logic selOut, input logic selSh, input logic [2:0] shimm,
                               output logic [7:0] got);
    logic [7:0]  expV;
    logic [31:0] expDp;
    int n;
    expV  = kind ? refResult(oper, selOut, model[rs1], model[rs2], selSh, shimm) : imm;
    expDp = 32'({model[rs1], model[rs2], oper, selOut, selSh, shimm});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = kind;
    cmd_rd = AW'(rd); cmd_rs1 = AW'(rs1); cmd_rs2 = AW'(rs2);
    cmd_imm = imm; cmd_oper = oper; cmd_sel_out = selOut;
    cmd_sel_shamt = selSh; cmd_shimm = shimm;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) checkOutput("accept_timeout", 32'(n), 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
      checkOutput("busy_in_flight", 32'(busy), 1);
      if (kind == CMD_EXEC) checkOutput("dp_operands", dpBundle(), expDp);
    end
    checkOutput("rsp_latency", 32'(n), kind ? 3 : 2);
    checkOutput("rsp_data", 32'(rsp_data), 32'(expV));
    checkOutput("rsp_rd", 32'(rsp_rd), 32'(rd));
    checkOutput("resp_dp_zero", dpBundle(), 0);
    model[rd] = expV;
    got = rsp_data;
  endtask

  task automatic completeResponse();
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 1);
  endtask

  initial begin
    logic [7:0] held;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_kind = 1'b0; cmd_rd = '0; cmd_rs1 = '0;
    cmd_rs2 = '0; cmd_imm = 8'd0; cmd_oper = 3'd0; cmd_sel_out = 1'b0;
    cmd_sel_shamt = 1'b0; cmd_shimm = 3'd0; rsp_ready = 1'b1;
    for (int i = 0; i < NREG; i++) model[i] = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset_dp", dpBundle(), 0);
    rst_n = 1'b1;

    // Basic load/add and immediate-dependent follow-up
    applyStimulus(CMD_LOADI, 0, 0, 0, 8'd80, 3'd0, 0, 0, 3'd0, data); completeResponse();
    applyStimulus(CMD_LOADI, 1, 0, 0, 8'd20, 3'd0, 0, 0, 3'd0, data); completeResponse();
    applyStimulus(CMD_EXEC, 2, 0, 1, 8'd0, OP_ADD_ASR, 0, 0, 3'd0, data);
    checkOutput("add_80_20", 32'(data), 100);
    completeResponse();
    applyStimulus(CMD_EXEC, 3, 2, 2, 8'd0, OP_ADD_ASR, 0, 0, 3'd0, data);
    checkOutput("dep_r2_plus_r2", 32'(data), 200);
    completeResponse();

    // Shifter path with immediate and register shift amounts
    applyStimulus(CMD_EXEC, 3, 0, 0, 8'd0, OP_ADD_ASR, 1, 1, 3'd2, data);
    checkOutput("asr_80_by_2", 32'(data), 20);
    completeResponse();
    applyStimulus(CMD_EXEC, 3, 0, 1, 8'd0, OP_AND_ROR, 1, 0, 3'd7, data);
    checkOutput("ror_80_by_r1", 32'(data), 5);
    completeResponse();

    // Modulo arithmetic corners
    applyStimulus(CMD_LOADI, 0, 0, 0, 8'd15, 3'd0, 0, 0, 3'd0, data); completeResponse();
    applyStimulus(CMD_LOADI, 1, 0, 0, 8'd26, 3'd0, 0, 0, 3'd0, data); completeResponse();
    applyStimulus(CMD_EXEC, 2, 0, 1, 8'd0, OP_SUB_LSR, 0, 0, 3'd0, data);
    checkOutput("sub_wrap", 32'(data), 245);
    completeResponse();
    applyStimulus(CMD_LOADI, 0, 0, 0, 8'd150, 3'd0, 0, 0, 3'd0, data); completeResponse();
    applyStimulus(CMD_EXEC, 0, 0, 0, 8'd0, OP_ADD_ASR, 0, 0, 3'd0, data);
    checkOutput("add_wrap_same_reg", 32'(data), 44);
    completeResponse();
    applyStimulus(CMD_LOADI, 0, 0, 0, 8'd0, 3'd0, 0, 0, 3'd0, data); completeResponse();
    applyStimulus(CMD_EXEC, 2, 0, 0, 8'd0, OP_NOT_ROL, 0, 0, 3'd0, data);
    checkOutput("not_zero", 32'(data), 255);
    completeResponse();

    // Response back-pressure while a second command is offered
    applyStimulus(CMD_LOADI, 1, 0, 0, 8'h3C, 3'd0, 0, 0, 3'd0, data);
    held = data;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_kind = CMD_LOADI; cmd_rd = AW'(2); cmd_imm = 8'hEE;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_rsp_valid", 32'(rsp_valid), 1);
      checkOutput("stall_rsp_data", 32'(rsp_data), 32'(held));
      checkOutput("stall_rsp_rd", 32'(rsp_rd), 1);
      checkOutput("stall_cmd_ready", 32'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    completeResponse();

    // Reset in ISSUE drops the command and clears every register
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = CMD_EXEC; cmd_rd = AW'(3); cmd_rs1 = AW'(1);
    cmd_rs2 = AW'(1); cmd_oper = OP_OR_LSL; cmd_sel_out = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("issue_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_dp", dpBundle(), 0);
    for (int i = 0; i < NREG; i++) model[i] = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 0);
    applyStimulus(CMD_EXEC, 0, 3, 3, 8'd0, OP_PASS, 0, 0, 3'd0, data);
    checkOutput("dropped_dest_zero", 32'(data), 0);
    completeResponse();

    // Randomized commands against the register model
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 2) != 0) ? CMD_EXEC : CMD_LOADI,
                    int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                    int'($urandom_range(0, NREG - 1)), 8'($urandom), 3'($urandom),
                    1'($urandom), 1'($urandom), 3'($urandom), data);
      completeResponse();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
